// File: rtl/mem_port_sched_pkg.sv
// Shared definitions for the memory-port scheduler: state encoding and
// default widths/limits.
package mem_port_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_FETCH = 2'd2,
    S_ADV   = 2'd3
  } state_t;

  localparam int unsigned AW_DEF       = 16;
  localparam int unsigned DW_DEF       = 16;
  localparam int unsigned MAX_WAIT_DEF = 15;
  localparam int unsigned WAIT_CW      = 8;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for an outstanding memory request. Flags expiry in the
// cycle that would bring the count to MAX_WAIT without an ack.
module mem_wait_timer
  import mem_port_sched_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [WAIT_CW-1:0] LIMIT = WAIT_CW'(MAX_WAIT - 1);

  logic [WAIT_CW-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset)        r_count <= '0;
    else if (i_clear)  r_count <= '0;
    else if (i_enable) r_count <= r_count + 1'b1;
  end

  assign o_expired = i_enable && (r_count == LIMIT);

endmodule

// File: rtl/mem_port_sched.sv
// Arbitrates the single unified memory port between data access and fetch,
// and releases the pipeline registers for one cycle once both are done.
module mem_port_sched
  import mem_port_sched_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF,
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          halt,
  input  logic          EXMEMmemRead,
  input  logic          EXMEMmemWrite,
  input  logic [AW-1:0] dataAddr,
  input  logic [DW-1:0] wrDataOut,
  input  logic          PCsrc,
  input  logic [AW-1:0] pc,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] instr_out,
  output logic [DW-1:0] data_out,
  output logic          wr_PC,
  output logic          wr_IFID,
  output logic          wr_IDEX,
  output logic          wr_EXMEM,
  output logic          wr_MEMWB,
  output logic          IFIDclear,
  output logic          IDEXclear,
  output logic          bus_err
);

  state_t        r_state, w_next;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata, r_instr, r_data;
  logic          r_we, r_data_done, r_bus_err;
  logic          w_busy, w_expired, w_adv, w_data_first;

  assign w_busy       = (r_state == S_DATA) || (r_state == S_FETCH);
  assign w_adv        = (r_state == S_ADV);
  // A load/store already served this instruction must not be repeated on a retry.
  assign w_data_first = (EXMEMmemRead || EXMEMmemWrite) && !r_data_done;

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (!w_busy || mem_ack),
    .i_enable (w_busy && !mem_ack),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: w_next gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (!halt) w_next = w_data_first ? S_DATA : S_FETCH;
      S_DATA:  if (mem_ack) w_next = S_FETCH; else if (w_expired) w_next = S_IDLE;
      S_FETCH: if (mem_ack) w_next = S_ADV;   else if (w_expired) w_next = S_IDLE;
      S_ADV:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_instr     <= '0;
      r_data      <= '0;
      r_data_done <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      if (w_expired) r_bus_err <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (!halt) begin
            if (w_data_first) begin
              r_addr  <= dataAddr;
              r_we    <= EXMEMmemWrite;
              r_wdata <= wrDataOut;
            end else begin
              r_addr <= pc;
              r_we   <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (mem_ack) begin
            if (!r_we) r_data <= mem_rdata;
            r_data_done <= 1'b1;
            r_addr      <= pc;
            r_we        <= 1'b0;
          end
        end
        S_FETCH: if (mem_ack) r_instr <= mem_rdata;
        S_ADV:   r_data_done <= 1'b0;
        default: ;
      endcase
    end
  end

  assign mem_req   = w_busy;
  assign mem_we    = (r_state == S_DATA) && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign instr_out = r_instr;
  assign data_out  = r_data;
  assign bus_err   = r_bus_err;

  assign wr_PC     = w_adv;
  assign wr_IFID   = w_adv;
  assign wr_IDEX   = w_adv;
  assign wr_EXMEM  = w_adv;
  assign wr_MEMWB  = w_adv;
  assign IFIDclear = w_adv && PCsrc;
  assign IDEXclear = w_adv && PCsrc;

endmodule

// File: tb/tb_mem_port_sched.sv
// Directed bench for mem_port_sched: a small memory responder with
// programmable ack latency and hand-computed expectations per cycle.
module tb_mem_port_sched;

  logic        clk = 1'b0;
  logic        reset, halt, EXMEMmemRead, EXMEMmemWrite, PCsrc, mem_ack;
  logic [15:0] dataAddr, wrDataOut, pc, mem_rdata;
  logic        mem_req, mem_we, bus_err;
  logic [15:0] mem_addr, mem_wdata, instr_out, data_out;
  logic        wr_PC, wr_IFID, wr_IDEX, wr_EXMEM, wr_MEMWB, IFIDclear, IDEXclear;

  int total = 0;
  int bad   = 0;
  int ack_delay = 0;
  bit ack_never = 1'b1;
  int req_cnt   = 0;

  localparam int EN_NONE  = 'h00;
  localparam int EN_ALL   = 'h7C;
  localparam int EN_FLUSH = 'h7F;

  always #5 clk = ~clk;

  mem_port_sched dut (
    .clk          (clk),
    .reset        (reset),
    .halt         (halt),
    .EXMEMmemRead (EXMEMmemRead),
    .EXMEMmemWrite(EXMEMmemWrite),
    .dataAddr     (dataAddr),
    .wrDataOut    (wrDataOut),
    .PCsrc        (PCsrc),
    .pc           (pc),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .instr_out    (instr_out),
    .data_out     (data_out),
    .wr_PC        (wr_PC),
    .wr_IFID      (wr_IFID),
    .wr_IDEX      (wr_IDEX),
    .wr_EXMEM     (wr_EXMEM),
    .wr_MEMWB     (wr_MEMWB),
    .IFIDclear    (IFIDclear),
    .IDEXclear    (IDEXclear),
    .bus_err      (bus_err)
  );

  function automatic logic [15:0] mem_lookup(input logic [15:0] a);
    case (a)
      16'h0010: return 16'hA5A5;
      16'h0011: return 16'h5A5A;
      16'h0200: return 16'h1234;
      default:  return ~a;
    endcase
  endfunction

  function automatic logic [6:0] en_vec();
    return {wr_PC, wr_IFID, wr_IDEX, wr_EXMEM, wr_MEMWB, IFIDclear, IDEXclear};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory model: acks in the (ack_delay+1)-th consecutive request cycle.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (mem_req !== 1'b1) begin
        req_cnt   = 0;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0;
      end else begin
        mem_ack   = !ack_never && (req_cnt == ack_delay);
        mem_rdata = mem_ack ? mem_lookup(mem_addr) : 16'h0;
        if (mem_ack) req_cnt = 0;
        else         req_cnt++;
      end
    end
  end

  initial begin
    reset = 1'b0; halt = 1'b1; EXMEMmemRead = 1'b0; EXMEMmemWrite = 1'b0; PCsrc = 1'b0;
    dataAddr = 16'h0; wrDataOut = 16'h0; pc = 16'h0010;

    step(); step();
    check("rst_req",   32'(mem_req),   0);
    check("rst_en",    32'(en_vec()),  EN_NONE);
    check("rst_instr", 32'(instr_out), 0);
    check("rst_data",  32'(data_out),  0);
    check("rst_addr",  32'(mem_addr),  0);
    check("rst_err",   32'(bus_err),   0);

    // Start a fetch that never gets acked, then reset it mid-flight.
    reset = 1'b1; halt = 1'b0;
    step();
    check("f0_req",  32'(mem_req),  1);
    check("f0_addr", 32'(mem_addr), 32'h0010);
    step();
    check("f0_hold", 32'(mem_req), 1);
    reset = 1'b0;
    step();
    check("midrst_req",  32'(mem_req),  0);
    check("midrst_we",   32'(mem_we),   0);
    check("midrst_addr", 32'(mem_addr), 0);
    check("midrst_en",   32'(en_vec()), EN_NONE);
    check("midrst_err",  32'(bus_err),  0);
    step();
    check("midrst_req2", 32'(mem_req), 0);

    // Plain fetch stream, ack in the first request cycle: 3-cycle period.
    reset = 1'b1; ack_never = 1'b0; ack_delay = 0;
    step();
    check("fa_req",  32'(mem_req),  1);
    check("fa_addr", 32'(mem_addr), 32'h0010);
    check("fa_we",   32'(mem_we),   0);
    check("fa_en",   32'(en_vec()), EN_NONE);
    step();
    check("fa_instr", 32'(instr_out), 32'hA5A5);
    check("fa_adv",   32'(en_vec()),  EN_ALL);
    check("fa_noreq", 32'(mem_req),   0);
    step();
    check("fa_idle_en",  32'(en_vec()), EN_NONE);
    check("fa_idle_req", 32'(mem_req),  0);
    step();
    check("fb_req", 32'(mem_req), 1);
    step();
    check("fb_adv", 32'(en_vec()), EN_ALL);
    EXMEMmemRead = 1'b1; dataAddr = 16'h0200; pc = 16'h0011;

    // Load then fetch, no IDLE bubble in between.
    step();
    check("ld_idle", 32'(mem_req), 0);
    step();
    check("ld_req",  32'(mem_req),  1);
    check("ld_we",   32'(mem_we),   0);
    check("ld_addr", 32'(mem_addr), 32'h0200);
    step();
    check("ld_data",   32'(data_out), 32'h1234);
    check("ld_faddr",  32'(mem_addr), 32'h0011);
    check("ld_freq",   32'(mem_req),  1);
    check("ld_fen",    32'(en_vec()), EN_NONE);
    step();
    check("ld_instr", 32'(instr_out), 32'h5A5A);
    check("ld_adv",   32'(en_vec()),  EN_ALL);
    EXMEMmemRead = 1'b0;

    // Store with a 5-cycle ack delay: request held stable for 6 cycles.
    step();
    EXMEMmemWrite = 1'b1; dataAddr = 16'h0300; wrDataOut = 16'hBEEF; ack_delay = 5;
    for (int i = 0; i < 6; i++) begin
      step();
      check("st_req",   32'(mem_req),   1);
      check("st_we",    32'(mem_we),    1);
      check("st_addr",  32'(mem_addr),  32'h0300);
      check("st_wdata", 32'(mem_wdata), 32'hBEEF);
      check("st_en",    32'(en_vec()),  EN_NONE);
    end
    step();
    check("st_fwe",   32'(mem_we),   0);
    check("st_faddr", 32'(mem_addr), 32'h0011);
    check("st_data",  32'(data_out), 32'h1234);
    ack_delay = 0; EXMEMmemWrite = 1'b0; PCsrc = 1'b1;
    #1;
    check("br_fetch_en", 32'(en_vec()), EN_NONE);

    // Taken branch: clears only during ADV.
    step();
    check("br_adv", 32'(en_vec()), EN_FLUSH);
    step();
    check("br_idle", 32'(en_vec()), EN_NONE);
    PCsrc = 1'b0; EXMEMmemRead = 1'b1; dataAddr = 16'h0400; pc = 16'h0012;

    // Load completes, fetch times out, retry must fetch (not reload).
    step();
    check("to_ldaddr", 32'(mem_addr), 32'h0400);
    step();
    check("to_data",  32'(data_out), 32'hFBFF);
    check("to_faddr", 32'(mem_addr), 32'h0012);
    check("to_freq",  32'(mem_req),  1);
    ack_never = 1'b1;
    for (int i = 1; i < 15; i++) begin
      step();
      check("to_wait_req", 32'(mem_req), 1);
      check("to_wait_err", 32'(bus_err), 0);
    end
    step();
    check("to_drop", 32'(mem_req),  0);
    check("to_err",  32'(bus_err),  1);
    check("to_en",   32'(en_vec()), EN_NONE);
    ack_never = 1'b0;
    step();
    check("rt_req",  32'(mem_req),  1);
    check("rt_addr", 32'(mem_addr), 32'h0012);
    check("rt_we",   32'(mem_we),   0);
    check("rt_err",  32'(bus_err),  1);
    step();
    check("rt_instr", 32'(instr_out), 32'hFFED);
    check("rt_adv",   32'(en_vec()),  EN_ALL);
    EXMEMmemRead = 1'b0; halt = 1'b1;

    // Halt holds IDLE; error flag is sticky.
    step(); step();
    check("halt_req", 32'(mem_req), 0);
    check("halt_err", 32'(bus_err), 1);
    reset = 1'b0;
    step();
    check("rst2_err", 32'(bus_err), 0);

    // Ack on the last allowed cycle wins over the timeout.
    reset = 1'b1; halt = 1'b0; pc = 16'h0010; ack_delay = 14;
    step();
    check("lim_req", 32'(mem_req), 1);
    for (int i = 0; i < 14; i++) begin
      step();
      check("lim_wait", 32'(mem_req), 1);
    end
    step();
    check("lim_adv",   32'(en_vec()),  EN_ALL);
    check("lim_err",   32'(bus_err),   0);
    check("lim_instr", 32'(instr_out), 32'hA5A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_sched.md
Name: mem_port_sched

Overview:
- Sequences the 5-stage pipeline around one single-ported unified memory shared by instruction fetch (IF) and the EX/MEM data access.
- Arbitrates that port between the two requesters. Data access always wins, because it belongs to the older instruction.
- Generates the pipeline-register write enables and clears (wr_PC, wr_IFID, wr_IDEX, wr_EXMEM, wr_MEMWB, *clear) so no stage advances until its memory traffic has completed.
- Sits beside the EX/MEM register and consumes its outputs directly.

Parameters:
- MAX_WAIT, 15, max cycles mem_req is held without mem_ack before timeout (1..255).
- AW, 16, address width.
- DW, 16, data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- halt  in  1  when 1, no new transaction is started from IDLE.
- EXMEMmemRead  in  1  EX/MEM holds a load.
- EXMEMmemWrite  in  1  EX/MEM holds a store.
- dataAddr  in  AW  load/store address from EX/MEM.
- wrDataOut  in  DW  store data from EX/MEM.
- PCsrc  in  1  EX/MEM holds a taken jump/branch.
- pc  in  AW  current PC value.
- mem_ack  in  1  memory completed the request this cycle.
- mem_rdata  in  DW  memory read data, valid with mem_ack.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  AW  request address.
- mem_wdata  out  DW  write data.
- instr_out  out  DW  last fetched instruction, feeds IF/ID.
- data_out  out  DW  last load data, feeds MEM/WB.
- wr_PC, wr_IFID, wr_IDEX, wr_EXMEM, wr_MEMWB  out  1 each  pipeline advance enables.
- IFIDclear, IDEXclear  out  1 each  flush of the younger stages.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Reset: synchronous, active-low, checked first in every cycle. Forces state = IDLE, wait counter = 0, data_done = 0, bus_err = 0 and every output = 0 (including instr_out and data_out).
- Reset mid-transaction: mem_req drops at that same edge. The abandoned request is lost; memory must tolerate this.
- Output timing: mem_req, mem_we and the wr_*/clear enables are Moore decodes of state. mem_addr, mem_wdata, instr_out, data_out and bus_err are registers.
- States: IDLE, DATA, FETCH, ADV.
- IDLE: all enables 0, mem_req 0.
  - halt=1: stay in IDLE.
  - (EXMEMmemRead|EXMEMmemWrite) & ~data_done: latch mem_addr=dataAddr, mem_we=EXMEMmemWrite, mem_wdata=wrDataOut; go to DATA.
  - Otherwise: latch mem_addr=pc, mem_we=0; go to FETCH.
  - If EXMEMmemRead and EXMEMmemWrite are both 1, treat it as a write.
- DATA: mem_req=1; address, we and wdata stay stable.
  - On mem_ack: if it was a read, data_out<=mem_rdata. Set data_done=1, latch mem_addr=pc, mem_we=0, go to FETCH (no IDLE bubble).
- FETCH: mem_req=1, mem_we=0.
  - On mem_ack: instr_out<=mem_rdata, go to ADV.
- ADV: exactly one cycle, then IDLE.
  - mem_req=0.
  - wr_PC, wr_IFID, wr_IDEX, wr_EXMEM and wr_MEMWB are all 1.
  - data_done cleared.
  - If PCsrc=1: IFIDclear=IDEXclear=1 as well. PC loads the target through the external PC mux; clear has priority over write in those registers.
- Throughput, counted from IDLE: minimum 3 cycles per instruction with no data access, 4 with a data access.
- mem_ack is ignored in IDLE and ADV.
- Timeout:
  - The 8-bit wait counter is cleared on entry to DATA/FETCH and increments each cycle with no ack.
  - When it reaches MAX_WAIT with mem_ack=0: set bus_err=1 (sticky until reset), return to IDLE and retry the same request; data_done is unchanged.
  - mem_ack arriving in the same cycle as the limit wins; no error is flagged.
- The pipeline never advances while a transaction is outstanding; all enables are 0 outside ADV.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, DATA=2'd1, FETCH=2'd2, ADV=2'd3);
  - AW/DW defaults;
  - the MAX_WAIT default.
- Natural sub-module: mem_wait_timer, the counter plus the limit compare with clear/enable/expired ports.
- The remainder is a single FSM file.

Test Plan:
- Reset low for 2 cycles mid-FETCH, with mem_req=1 -> mem_req=0 at the first sampled edge; all outputs 0; state IDLE; bus_err=0.
- No data access, pc=16'h0010, mem_ack one cycle after mem_req rises, rdata=16'hA5A5 -> instr_out=16'hA5A5; ADV one cycle with all wr_*=1; 3-cycle period repeats.
- EXMEMmemRead=1, dataAddr=16'h0200, ack with rdata=16'h1234, then fetch pc=16'h0011 -> DATA precedes FETCH; data_out=16'h1234; the second request's address is 16'h0011; only one ADV; no repeated load.
- EXMEMmemWrite=1, dataAddr=16'h0300, wrDataOut=16'hBEEF, ack delayed 5 cycles -> mem_we=1, mem_addr=16'h0300 and mem_wdata=16'hBEEF held stable for 6 cycles; all wr_*=0 meanwhile.
- PCsrc=1 during ADV -> IFIDclear=IDEXclear=1 for exactly that cycle alongside wr_PC=1.
- Ack never arrives with MAX_WAIT=15 -> mem_req drops after 15 wait cycles; bus_err=1 and stays 1; the same address is re-requested; a subsequent ack completes normally.
